// File: rtl/detector_rr_scheduler_if.sv
// Bundle between frame producers (master) and the shared-detector scheduler (slave).
// Result fields (done_id, hit_cnt, bits_used) are held between done pulses.
interface detector_rr_scheduler_if #(
    parameter int N_REQ   = 4,
    parameter int FRAME_W = 8
);
    localparam int CNT_W = $clog2(FRAME_W + 1);
    localparam int ID_W  = $clog2(N_REQ);

    logic [N_REQ-1:0]         req;
    logic [N_REQ*FRAME_W-1:0] frame_data;
    logic [N_REQ-1:0]         gnt;
    logic                     busy;
    logic                     done;
    logic [ID_W-1:0]          done_id;
    logic [CNT_W-1:0]         hit_cnt;
    logic [CNT_W-1:0]         bits_used;

    modport master (
        output req, frame_data,
        input  gnt, busy, done, done_id, hit_cnt, bits_used
    );

    modport slave (
        input  req, frame_data,
        output gnt, busy, done, done_id, hit_cnt, bits_used
    );
endinterface

// File: rtl/detector_rr_scheduler.sv
// Round-robin share of one 2-bit serial pattern detector; optional DETSCHED_EARLY_STOP_EN stops on first hit.
// Latency: gnt cycle to done pulse is FRAME_W+1 cycles (less with early stop); at least one idle cycle between jobs.
// Backpressure: none; requests are only sampled while idle, an ungranted dropped req is forgotten.
module detector_rr_scheduler #(
    parameter int N_REQ   = 4,
    parameter int FRAME_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    detector_rr_scheduler_if.slave   bus
);
    localparam int CNT_W = $clog2(FRAME_W + 1);
    localparam int ID_W  = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    cur_id;
    logic [FRAME_W-1:0] shreg;
    logic [1:0]         q;
    logic [CNT_W-1:0]   bit_ctr;
    logic [CNT_W-1:0]   hcnt;

    logic [N_REQ-1:0]   gnt_q;
    logic               busy_q;
    logic               done_q;
    logic [ID_W-1:0]    done_id_q;
    logic [CNT_W-1:0]   hit_cnt_q;
    logic [CNT_W-1:0]   bits_used_q;

    // First asserted request at or after rr_ptr; iterating downwards lets the nearest one win.
    logic               pick_vld;
    logic [ID_W-1:0]    pick_id;
    int                 idx;

    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        idx      = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = int'(rr_ptr) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (bus.req[idx[ID_W-1:0]]) begin
                pick_vld = 1'b1;
                pick_id  = ID_W'(idx);
            end
        end
    end

    logic [ID_W-1:0] rr_next;
    assign rr_next = (pick_id == ID_W'(N_REQ - 1)) ? '0 : pick_id + 1'b1;

    logic a, q0_n, q1_n, hit;
    assign a    = shreg[0];
    assign q0_n = a ^ q[0] ^ q[1];
    assign q1_n = (~q[0] & ~q[1]) | (~a & q[1]);
    assign hit  = q1_n & q0_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            cur_id      <= '0;
            shreg       <= '0;
            q           <= 2'b00;
            bit_ctr     <= '0;
            hcnt        <= '0;
            gnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            done_id_q   <= '0;
            hit_cnt_q   <= '0;
            bits_used_q <= '0;
        end else begin
            gnt_q  <= '0;
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        gnt_q   <= N_REQ'(1) << pick_id;
                        shreg   <= bus.frame_data[int'(pick_id)*FRAME_W +: FRAME_W];
                        q       <= 2'b00;
                        bit_ctr <= '0;
                        hcnt    <= '0;
                        cur_id  <= pick_id;
                        rr_ptr  <= rr_next;
                        busy_q  <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    q       <= {q1_n, q0_n};
                    shreg   <= shreg >> 1;
                    bit_ctr <= bit_ctr + 1'b1;
                    if (hit) hcnt <= hcnt + 1'b1;
                    if (bit_ctr == CNT_W'(FRAME_W - 1)) state <= DONE;
`ifdef DETSCHED_EARLY_STOP_EN
                    if (hit) state <= DONE;
`else
`endif
                end
                DONE: begin
                    done_q      <= 1'b1;
                    done_id_q   <= cur_id;
                    hit_cnt_q   <= hcnt;
                    bits_used_q <= bit_ctr;
                    busy_q      <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.done_id   = done_id_q;
    assign bus.hit_cnt   = hit_cnt_q;
    assign bus.bits_used = bits_used_q;
endmodule

// File: tb/tb_detector_rr_scheduler.sv
// Directed bench for detector_rr_scheduler: single jobs, round-robin order, mid-frame reset, frame snapshot.
module tb_detector_rr_scheduler;
    localparam int N_REQ   = 4;
    localparam int FRAME_W = 8;

`ifdef DETSCHED_EARLY_STOP_EN
    localparam int LAT00 = 3, HIT00 = 1, BITS00 = 2;
    localparam int LATFF = 2, HITFF = 1, BITSFF = 1;
`else
    localparam int LAT00 = 9, HIT00 = 4, BITS00 = 8;
    localparam int LATFF = 9, HITFF = 3, BITSFF = 8;
`endif
    // 8'hAA never hits, so both builds shift it completely.
    localparam int LATAA = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    detector_rr_scheduler_if #(.N_REQ(N_REQ), .FRAME_W(FRAME_W)) bus ();

    detector_rr_scheduler #(.N_REQ(N_REQ), .FRAME_W(FRAME_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_gnt(input int max, output int n);
        n = 0;
        while (bus.gnt == '0 && n < max) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_done(input int max, output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < max) begin
            tick();
            n++;
        end
    endtask

    int n;
    int last_done;
    int exp_order [5] = '{0, 1, 2, 3, 0};

    initial begin
        bus.req        = '0;
        bus.frame_data = '0;

        // Reset state
        tick();
        chk("rst_gnt",   32'(bus.gnt), 0);
        chk("rst_busy",  32'(bus.busy), 0);
        chk("rst_done",  32'(bus.done), 0);
        chk("rst_id",    32'(bus.done_id), 0);
        chk("rst_hit",   32'(bus.hit_cnt), 0);
        chk("rst_bits",  32'(bus.bits_used), 0);

        // Requester 0, frame 8'h00
        rst = 1'b0;
        bus.req = 4'b0001;
        bus.frame_data = 32'h0000_0000;
        tick();
        chk("t1_gnt",  32'(bus.gnt), 32'b0001);
        chk("t1_busy", 32'(bus.busy), 1);
        bus.req = '0;
        tick();
        chk("t1_gnt_pulse", 32'(bus.gnt), 0);
        wait_done(20, n);
        chk("t1_lat",  32'(n + 1), 32'(LAT00));
        chk("t1_id",   32'(bus.done_id), 0);
        chk("t1_hit",  32'(bus.hit_cnt), 32'(HIT00));
        chk("t1_bits", 32'(bus.bits_used), 32'(BITS00));
        tick();
        chk("t1_done_pulse", 32'(bus.done), 0);
        chk("t1_hit_hold",   32'(bus.hit_cnt), 32'(HIT00));

        // Requester 2, frame 8'hFF
        bus.req = 4'b0100;
        bus.frame_data = 32'h00FF_0000;
        tick();
        chk("t2_gnt", 32'(bus.gnt), 32'b0100);
        bus.req = '0;
        wait_done(20, n);
        chk("t2_lat",  32'(n), 32'(LATFF));
        chk("t2_id",   32'(bus.done_id), 2);
        chk("t2_hit",  32'(bus.hit_cnt), 32'(HITFF));
        chk("t2_bits", 32'(bus.bits_used), 32'(BITSFF));

        // All requesters held high from reset: order 0,1,2,3,0
        rst = 1'b1;
        tick();
        bus.req = 4'b1111;
        bus.frame_data = 32'h0000_0000;
        tick();
        chk("t3_rst_gnt", 32'(bus.gnt), 0);
        rst = 1'b0;
        last_done = 0;
        for (int j = 0; j < 5; j++) begin
            wait_gnt(20, n);
            chk($sformatf("t3_gnt%0d", j), 32'(bus.gnt), 32'(1) << exp_order[j]);
            wait_done(20, n);
            chk($sformatf("t3_id%0d", j), 32'(bus.done_id), 32'(exp_order[j]));
            if (j > 0) chk($sformatf("t3_period%0d", j), 32'(cyc - last_done), 32'(LAT00 + 1));
            last_done = cyc;
        end

        // Reset on the 4th SHIFT cycle of requester 1's frame
        bus.req = 4'b0010;
        bus.frame_data = 32'h0000_AA00;
        wait_gnt(20, n);
        chk("t4_gnt", 32'(bus.gnt), 32'b0010);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("t4_busy", 32'(bus.busy), 0);
        chk("t4_done", 32'(bus.done), 0);
        chk("t4_hit",  32'(bus.hit_cnt), 0);
        chk("t4_gnt0", 32'(bus.gnt), 0);
        rst = 1'b0;
        tick();
        chk("t4_regnt", 32'(bus.gnt), 32'b0010);
        bus.req = '0;
        wait_done(20, n);
        chk("t4_lat",  32'(n), 32'(LATAA));
        chk("t4_id",   32'(bus.done_id), 1);
        chk("t4_hit2", 32'(bus.hit_cnt), 0);
        chk("t4_bits", 32'(bus.bits_used), 8);

        // Frame is a snapshot: change it right after the grant
        bus.req = 4'b0001;
        bus.frame_data = 32'h0000_0000;
        tick();
        chk("t5_gnt", 32'(bus.gnt), 32'b0001);
        bus.req = '0;
        bus.frame_data = 32'h0000_00FF;
        wait_done(20, n);
        chk("t5_lat",  32'(n), 32'(LAT00));
        chk("t5_hit",  32'(bus.hit_cnt), 32'(HIT00));
        chk("t5_bits", 32'(bus.bits_used), 32'(BITS00));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
